// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: lane steering, extension, alignment checks and a
// handshake memory port with timeout.
module load_store_unit #(
  parameter int MEM_ADDR_W = 12,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  input  logic [4:0]            i_req_rd,
  output logic                  o_mem_req,
  output logic [3:0]            o_mem_we,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_resp_valid,
  output logic                  o_resp_wb,
  output logic [31:0]           o_resp_data,
  output logic [4:0]            o_resp_rd,
  output logic                  o_resp_err,
  output logic                  o_stall
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_off;
  logic [MEM_ADDR_W-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic [4:0]            r_rd;
  logic                  r_err;
  logic [31:0]           r_data;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_misaligned;
  logic                  w_timeout;
  logic [7:0]            w_lane_b;
  logic [15:0]           w_lane_h;
  logic [31:0]           w_load;
  logic [3:0]            w_strb;
  logic [31:0]           w_wdata_rep;
  logic                  w_unused_addr;

  // Only the word-address bits reach memory; the rest are deliberately dropped.
  assign w_unused_addr = ^i_req_addr[31:MEM_ADDR_W+2];

  assign w_misaligned = (i_req_size == 2'b11)
                      | ((i_req_size == 2'b01) & i_req_addr[0])
                      | ((i_req_size == 2'b10) & (|i_req_addr[1:0]));

  assign w_timeout = (MAX_WAIT != 0) && (r_cnt == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    w_lane_b = i_mem_rdata[31:24];
    case (r_off)
      2'd0:    w_lane_b = i_mem_rdata[31:24];
      2'd1:    w_lane_b = i_mem_rdata[23:16];
      2'd2:    w_lane_b = i_mem_rdata[15:8];
      default: w_lane_b = i_mem_rdata[7:0];
    endcase
  end

  assign w_lane_h = r_off[1] ? i_mem_rdata[15:0] : i_mem_rdata[31:16];

  always_comb begin
    w_load = i_mem_rdata;
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_lane_b[7]}}, w_lane_b};
      2'b01:   w_load = {{16{r_signed & w_lane_h[15]}}, w_lane_h};
      default: w_load = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_strb      = 4'b0000;
    w_wdata_rep = r_wdata;
    case (r_size)
      2'b00: begin
        w_strb      = 4'b1000 >> r_off;
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb      = r_off[1] ? 4'b0011 : 4'b1100;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_strb      = 4'b1111;
        w_wdata_rep = r_wdata;
      end
      default: begin
        w_strb      = 4'b0000;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_stall      = 1'b1;
    o_mem_req    = 1'b0;
    o_mem_we     = 4'b0000;
    o_mem_addr   = '0;
    o_mem_wdata  = 32'd0;
    o_resp_valid = 1'b0;
    o_resp_wb    = 1'b0;
    o_resp_err   = 1'b0;
    o_resp_data  = 32'd0;
    o_resp_rd    = 5'd0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        o_stall     = 1'b0;
        if (i_req_valid) begin
          w_next = w_misaligned ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_req   = 1'b1;
        o_mem_we    = r_we ? w_strb : 4'b0000;
        o_mem_addr  = r_waddr;
        o_mem_wdata = w_wdata_rep;
        // An ack arriving on the timeout cycle still completes the access cleanly.
        if (i_mem_ack || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_wb    = ~r_we & ~r_err;
        o_resp_err   = r_err;
        o_resp_data  = r_data;
        o_resp_rd    = r_rd;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_off    <= 2'b00;
      r_waddr  <= '0;
      r_wdata  <= 32'd0;
      r_rd     <= 5'd0;
      r_err    <= 1'b0;
      r_data   <= 32'd0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_req_valid) begin
            r_we     <= i_req_we;
            r_size   <= i_req_size;
            r_signed <= i_req_signed;
            r_off    <= i_req_addr[1:0];
            r_waddr  <= i_req_addr[MEM_ADDR_W+1:2];
            r_wdata  <= i_req_wdata;
            r_rd     <= i_req_rd;
            r_err    <= w_misaligned;
            r_data   <= 32'd0;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_mem_ack) begin
            r_err  <= 1'b0;
            r_data <= r_we ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_data <= 32'd0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized bench for load_store_unit against an
// arithmetic reference model.
module tb_load_store_unit;

  localparam int MAW = 12;
  localparam int MW  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready, req_we, req_signed;
  logic [1:0]     req_size;
  logic [31:0]    req_addr, req_wdata;
  logic [4:0]     req_rd;
  logic           mem_req, mem_ack;
  logic [3:0]     mem_we;
  logic [MAW-1:0] mem_addr;
  logic [31:0]    mem_wdata, mem_rdata;
  logic           resp_valid, resp_wb, resp_err, stall;
  logic [31:0]    resp_data;
  logic [4:0]     resp_rd;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_ADDR_W(MAW), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_rd(req_rd),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_resp_valid(resp_valid), .o_resp_wb(resp_wb), .o_resp_data(resp_data),
    .o_resp_rd(resp_rd), .o_resp_err(resp_err), .o_stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                           input logic [1:0] off, input logic [31:0] rdata);
    int unsigned v;
    if (size == 2'b00) begin
      v = (rdata >> (8 * (3 - off))) & 32'hFF;
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'b01) begin
      v = (rdata >> (8 * (2 - off))) & 32'hFFFF;
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // ack_at: access cycle (1 = first cycle after acceptance) in which mem_ack is driven; 0 = never.
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                      input int ack_at, input logic [31:0] rdata);
    logic        bad_align, exp_to, exp_err, exp_wb;
    int          exp_resp, exp_reqs, cyc, resp_cyc, req_cnt, stall_cnt, bad;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd, exp_data, got_data;
    logic [4:0]  got_rd;
    logic        got_err, got_wb;
    bad_align = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 0);
    exp_to    = !bad_align && (ack_at == 0 || ack_at > MW);
    exp_err   = bad_align || exp_to;
    exp_resp  = bad_align ? 1 : (exp_to ? MW + 1 : ack_at + 1);
    exp_reqs  = bad_align ? 0 : exp_resp - 1;
    exp_wb    = !we && !exp_err;
    exp_data  = (exp_err || we) ? 32'd0 : ref_load(size, sgn, addr[1:0], rdata);
    exp_strb  = 4'b0000;
    exp_wd    = wdata;
    if (size == 2'b00) begin
      exp_strb = 4'(1 << (3 - addr[1:0]));
      exp_wd   = wdata[7:0] * 32'h01010101;
    end else if (size == 2'b01) begin
      exp_strb = 4'(3 << (2 - addr[1:0]));
      exp_wd   = wdata[15:0] * 32'h00010001;
    end else begin
      exp_strb = 4'b1111;
    end
    if (!we) exp_strb = 4'b0000;

    @(negedge clk);
    check({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    cyc = 1; resp_cyc = 0; req_cnt = 0; stall_cnt = 0; bad = 0;
    got_data = 32'd0; got_rd = 5'd0; got_err = 1'b0; got_wb = 1'b0;
    while (resp_cyc == 0 && cyc <= 40) begin
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (mem_addr !== addr[MAW+1:2] || mem_we !== exp_strb) bad++;
        if (we && mem_wdata !== exp_wd) bad++;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        got_data = resp_data; got_rd = resp_rd; got_err = resp_err; got_wb = resp_wb;
      end else begin
        mem_ack   = (cyc == ack_at);
        mem_rdata = (cyc == ack_at) ? rdata : $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    check({tag, "/latency"}, resp_cyc, exp_resp);
    check({tag, "/mem_req_cycles"}, req_cnt, exp_reqs);
    check({tag, "/stall_cycles"}, stall_cnt, exp_resp);
    check({tag, "/mem_port"}, bad, 0);
    check({tag, "/err_wb"}, {30'd0, got_err, got_wb}, {30'd0, exp_err, exp_wb});
    check({tag, "/data"}, got_data, exp_data);
    check({tag, "/rd"}, {27'd0, got_rd}, {27'd0, rd});
    @(negedge clk);
    check({tag, "/after"}, {29'd0, req_ready, resp_valid, stall}, 32'b100);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #1;
    check("reset/ctrl", {26'd0, req_ready, mem_req, resp_valid, resp_wb, resp_err, stall},
          32'b100000);
    check("reset/mem", {mem_we, 16'(mem_addr), 12'd0} | mem_wdata, 32'd0);
    check("reset/resp", {27'd0, resp_rd} | resp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    xact("lb_signed", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 5'd3, 1, 32'h12F45678);
    xact("sh", 1'b1, 2'b01, 1'b0, 32'h106, 32'h0000BEEF, 5'd4, 2, 32'h0);
    xact("lw_misaligned", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 5'd5, 1, 32'h0);
    xact("lhu_wait", 1'b0, 2'b01, 1'b0, 32'h002, 32'h0, 5'd6, 5, 32'hAAAA8001);
    xact("timeout", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd7, 0, 32'h0);
    xact("ack_at_limit", 1'b0, 2'b10, 1'b1, 32'h204, 32'h0, 5'd8, MW, 32'h80000001);
    xact("illegal_size", 1'b1, 2'b11, 1'b0, 32'h300, 32'h1234, 5'd9, 1, 32'h0);
    xact("sw", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, 5'd10, 3, 32'h0);

    // Ack while idle must not start anything.
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack", {29'd0, req_ready, resp_valid, mem_req}, 32'b100);

    // Reset in the third access cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40; req_rd = 5'd11;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid/pre", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid/now", {29'd0, mem_req, req_ready, stall}, 32'b010);
    @(negedge clk);
    check("rst_mid/no_resp", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/idle", {30'd0, resp_valid, req_ready}, 32'b01);
    xact("lbu_after_rst", 1'b0, 2'b00, 1'b0, 32'h0A3, 32'h0, 5'd12, 1, 32'h000000F0);

    for (int i = 0; i < 30; i++) begin
      automatic int sel = $urandom_range(0, 4);
      automatic int ack = (sel == 0) ? 17 + $urandom_range(0, 3) : $urandom_range(1, 8);
      if (sel == 1) ack = MW;
      xact($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
           $urandom, 5'($urandom), ack, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
